// File: rtl/encoder_pkg.sv
// Shared types and constants for the encoder round sequencer.
package encoder_pkg;

  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned STAGE_W    = 2;
  localparam int unsigned ROUND_W    = 5;
  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 25;

  // Stage slots in the launch/done/memory vectors
  localparam int unsigned STG_COLPARITY = 0;
  localparam int unsigned STG_ROTATE    = 1;
  localparam int unsigned STG_PERMUTE   = 2;
  localparam int unsigned STG_REVALUATE = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  // One-hot mask selecting a single stage
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [STAGE_W-1:0] stage);
    stage_onehot = NUM_STAGES'(1) << stage;
  endfunction

endpackage

// File: rtl/enc_mem_mux.sv
// Combinational line-memory port mux: only the active stage reaches memory.
module enc_mem_mux
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                         i_active,
  input  logic [STAGE_W-1:0]           i_stage,
  input  logic [NUM_STAGES*ADDR_W-1:0] i_stg_addr,
  input  logic [NUM_STAGES-1:0]        i_stg_wr_en,
  input  logic [NUM_STAGES*DATA_W-1:0] i_stg_wr_data,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic                         o_mem_wr_en,
  output logic [DATA_W-1:0]            o_mem_wr_data
);

  // Forward the selected stage's fields while a run is active, else drive zero
  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_data = '0;
    if (i_active) begin
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
        if (i_stage == STAGE_W'(s)) begin
          o_mem_addr    = i_stg_addr[s*ADDR_W +: ADDR_W];
          o_mem_wr_en   = i_stg_wr_en[s];
          o_mem_wr_data = i_stg_wr_data[s*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/encoder_sequencer.sv
// Sequences four encoder stages for NUM_ROUNDS passes and arbitrates the line memory.
module encoder_sequencer
  import encoder_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic [NUM_STAGES-1:0]        stg_start,
  input  logic [NUM_STAGES-1:0]        stg_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STAGES-1:0]        stg_wr_en,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_wr_data,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wr_en,
  output logic [DATA_W-1:0]            mem_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [ROUND_W-1:0]           round_idx,
  output logic                         err
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [STAGE_W-1:0] FIRST_STG  = STAGE_W'(STG_COLPARITY);
  localparam logic [STAGE_W-1:0] LAST_STG   = STAGE_W'(STG_REVALUATE);

  seq_state_e                r_state;
  logic [STAGE_W-1:0]        r_stage;
  logic [ROUND_W-1:0]        r_round;
  logic                      r_err;

  seq_state_e                w_state_nxt;
  logic [STAGE_W-1:0]        w_stage_nxt;
  logic [ROUND_W-1:0]        w_round_nxt;
  logic                      w_err_nxt;
  logic [NUM_STAGES-1:0]     w_stg_start;
  logic                      w_done;
  logic [NUM_STAGES-1:0]     w_active_mask;
  logic                      w_own_done;
  logic                      w_multi_done;
  logic                      w_proto_err;

  // Protocol-check terms derived from the done vector and the active stage
  assign w_active_mask = stage_onehot(r_stage);
  assign w_own_done    = |(stg_done & w_active_mask);
  assign w_multi_done  = (stg_done & (stg_done - NUM_STAGES'(1))) != '0;
  assign w_proto_err   = (r_state == ST_WAIT)
                         ? ((|(stg_done & ~w_active_mask)) | w_multi_done)
                         : (|stg_done);

  // State, stage, round and error registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_stage <= FIRST_STG;
      r_round <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_round <= w_round_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, counter and pulse decode; abort preempts everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_round_nxt = r_round;
    w_err_nxt   = r_err;
    w_stg_start = '0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_stage_nxt = FIRST_STG;
          w_round_nxt = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stg_start = w_active_mask;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_own_done) begin
          if (r_stage != LAST_STG) begin
            w_stage_nxt = r_stage + STAGE_W'(1);
            w_state_nxt = ST_LAUNCH;
          end else if (r_round < LAST_ROUND) begin
            w_round_nxt = r_round + ROUND_W'(1);
            w_stage_nxt = FIRST_STG;
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
        if (!abort) begin
          w_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Sticky error; a same-cycle start in IDLE does not mask a fresh violation
    if (w_proto_err) begin
      w_err_nxt = 1'b1;
    end
  end

  assign stg_start = w_stg_start;
  assign done      = w_done;
  assign busy      = (r_state != ST_IDLE);
  assign round_idx = r_round;
  assign err       = r_err;

  // Line-memory arbitration for the active stage
  enc_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_mux (
    .i_active      (busy),
    .i_stage       (r_stage),
    .i_stg_addr    (stg_addr),
    .i_stg_wr_en   (stg_wr_en),
    .i_stg_wr_data (stg_wr_data),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_data (mem_wr_data)
  );

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed bench for encoder_sequencer with a two-cycle-latency stage model.
module tb_encoder_sequencer;

  localparam int AW = 7;
  localparam int DW = 25;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic [3:0]      stg_start;
  logic [3:0]      stg_done;
  logic [4*AW-1:0] stg_addr;
  logic [3:0]      stg_wr_en;
  logic [4*DW-1:0] stg_wr_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_data;
  logic            busy;
  logic            done;
  logic [4:0]      round_idx;
  logic            err;

  int         n_total;
  int         n_bad;
  int         cyc;
  int         pend [4];
  logic [3:0] force_done;

  encoder_sequencer #(
    .NUM_ROUNDS (2),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .stg_start   (stg_start),
    .stg_done    (stg_done),
    .stg_addr    (stg_addr),
    .stg_wr_en   (stg_wr_en),
    .stg_wr_data (stg_wr_data),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .round_idx   (round_idx),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int s);
    return AW'(32'h05 + 32'(s) * 32'h10);
  endfunction

  function automatic logic [DW-1:0] dat_of(input int s);
    return DW'(32'h1A0000 + 32'(s) * 32'h111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_pend();
    for (int s = 0; s < 4; s++) pend[s] = -1;
  endtask

  // Advance one cycle; stage models answer each launch two cycles later
  task automatic tick();
    logic [3:0] d;
    @(posedge clk);
    #1;
    cyc++;
    d = '0;
    for (int s = 0; s < 4; s++) begin
      if (pend[s] == cyc) begin
        d[s]    = 1'b1;
        pend[s] = -1;
      end
    end
    stg_done = d | force_done;
    #1;
    for (int s = 0; s < 4; s++) begin
      if (stg_start[s]) pend[s] = cyc + 2;
    end
  endtask

  // Full NUM_ROUNDS=2 run with closed-form timing: launches every 3 cycles
  task automatic run_nominal(input string tag, input logic [3:0] we);
    logic [3:0] es;
    int         st;
    logic       bz;
    stg_wr_en = we;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 26; r++) begin
      if (r > 1) tick();
      es = ((r <= 22) && ((r - 1) % 3 == 0)) ? (4'b0001 << (((r - 1) / 3) % 4)) : 4'b0000;
      st = (r <= 24) ? (((r - 1) / 3) % 4) : 3;
      bz = (r <= 25);
      chk({tag, "_stg_start"}, 32'(stg_start), 32'(es));
      chk({tag, "_done"},      32'(done),      32'(r == 25));
      chk({tag, "_busy"},      32'(busy),      32'(bz));
      chk({tag, "_round"},     32'(round_idx), (r >= 13) ? 32'd1 : 32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  bz ? 32'(addr_of(st)) : 32'd0);
      chk({tag, "_mem_we"},    32'(mem_wr_en), bz ? 32'(we[st]) : 32'd0);
      chk({tag, "_mem_data"},  32'(mem_wr_data), bz ? 32'(dat_of(st)) : 32'd0);
    end
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    cyc        = 0;
    force_done = '0;
    clear_pend();
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    stg_done   = '0;
    stg_wr_en  = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      stg_addr[s*AW +: AW]    = addr_of(s);
      stg_wr_data[s*DW +: DW] = dat_of(s);
    end

    // Reset state
    repeat (3) tick();
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_start", 32'(stg_start), 32'd0);
    chk("rst_round", 32'(round_idx), 32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_we",    32'(mem_wr_en), 32'd0);
    chk("rst_addr",  32'(mem_addr),  32'd0);
    rst = 1'b1;
    tick();

    // abort together with start in IDLE keeps the block idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy",  32'(busy),      32'd0);
    chk("idle_abort_start", 32'(stg_start), 32'd0);
    tick();

    // Nominal run, every stage requesting writes
    run_nominal("nom", 4'b1111);

    // Abort in WAIT of stage 2, round 0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 2; r <= 7; r++) tick();
    chk("ab_launch2", 32'(stg_start), 32'b0100);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    clear_pend();
    chk("ab_busy",  32'(busy),      32'd0);
    chk("ab_done",  32'(done),      32'd0);
    chk("ab_round", 32'(round_idx), 32'd0);
    chk("ab_start", 32'(stg_start), 32'd0);
    tick();

    // Restart after abort; only stages 0 and 2 request writes
    run_nominal("rerun", 4'b0101);

    // Foreign done from stage 3 alongside stage 1's own done
    stg_wr_en = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 2; r <= 5; r++) tick();
    chk("perr_pre", 32'(err), 32'd0);
    force_done = 4'b1000;
    tick();
    force_done = '0;
    tick();
    chk("perr_err",     32'(err),       32'd1);
    chk("perr_advance", 32'(stg_start), 32'b0100);
    for (int r = 8; r <= 25; r++) tick();
    chk("perr_done",      32'(done), 32'd1);
    chk("perr_err_done",  32'(err),  32'd1);
    tick();
    chk("perr_idle_busy", 32'(busy), 32'd0);
    chk("perr_idle_err",  32'(err),  32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("perr_clear", 32'(err),  32'd0);
    chk("perr_busy",  32'(busy), 32'd1);
    // abort during LAUNCH suppresses the launch pulse
    abort = 1'b1;
    #1;
    chk("launch_abort_start", 32'(stg_start), 32'd0);
    clear_pend();
    tick();
    abort = 1'b0;
    chk("launch_abort_busy", 32'(busy), 32'd0);

    // stg_done in IDLE flags an error
    force_done = 4'b0001;
    tick();
    force_done = '0;
    tick();
    chk("idle_done_err", 32'(err), 32'd1);

    // Mid-run reset during round 1
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mrst_clear_err", 32'(err), 32'd0);
    for (int r = 2; r <= 14; r++) tick();
    chk("mrst_round1", 32'(round_idx), 32'd1);
    rst = 1'b0;
    clear_pend();
    tick();
    rst = 1'b1;
    chk("mrst_busy",  32'(busy),        32'd0);
    chk("mrst_done",  32'(done),        32'd0);
    chk("mrst_start", 32'(stg_start),   32'd0);
    chk("mrst_round", 32'(round_idx),   32'd0);
    chk("mrst_err",   32'(err),         32'd0);
    chk("mrst_we",    32'(mem_wr_en),   32'd0);
    chk("mrst_addr",  32'(mem_addr),    32'd0);
    chk("mrst_data",  32'(mem_wr_data), 32'd0);
    // start on the first edge after reset release is accepted
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_launch", 32'(stg_start), 32'b0001);
    for (int r = 2; r <= 24; r++) begin
      tick();
      chk("post_rst_nodone", 32'(done), 32'd0);
    end
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    // start during FINISH is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin_start_busy",  32'(busy),      32'd0);
    tick();
    chk("fin_start_busy2", 32'(busy),      32'd0);
    chk("fin_start_launch", 32'(stg_start), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
